// File: rtl/cordic_nco_sched.sv
// -----------------------------------------------------------------------------
// cordic_nco_sched
//
// Multi-channel NCO front end sharing one fixed-latency CORDIC sin/cos core.
// Each channel owns a frequency control word, a phase offset and a phase
// accumulator. Per-channel sample requests are latched as "pending". A
// round-robin arbiter grants at most one pending channel per cycle. The
// granted channel's phase (acc + off) is sent to the core and its accumulator
// advances by fcw. A tag delay line follows each issued phase through the
// core so the result leaves the block labelled with its channel.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cfg_we/ch/fcw/off   config write: loads fcw/off of cfg_ch, clears its acc
//   ch_en [NCH]         per-channel enable (disabled channels drop requests)
//   req   [NCH]         one-cycle sample requests
//   ovf_clr             clears every sticky overrun flag
//   pending [NCH]       registered request-pending status
//   ovf     [NCH]       sticky overrun (request merged into an older one)
//   cordic_phase        registered phase driven to the core
//   cordic_sin/cos      core results, LAT cycles after the phase is issued
//   out_valid/ch/sin/cos registered, channel-tagged results
// -----------------------------------------------------------------------------
module cordic_nco_sched #(
    parameter int NCH = 4,
    parameter int PW  = 32,
    parameter int LAT = 35,
    parameter int OW  = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(NCH)-1:0]   cfg_ch,
    input  logic [PW-1:0]            cfg_fcw,
    input  logic [PW-1:0]            cfg_off,
    input  logic [NCH-1:0]           ch_en,
    input  logic [NCH-1:0]           req,
    input  logic                     ovf_clr,
    output logic [NCH-1:0]           pending,
    output logic [NCH-1:0]           ovf,
    output logic [PW-1:0]            cordic_phase,
    input  logic [OW-1:0]            cordic_sin,
    input  logic [OW-1:0]            cordic_cos,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [OW-1:0]            out_sin,
    output logic [OW-1:0]            out_cos
);

    localparam int CW = $clog2(NCH);

    // Per-channel configuration and phase state
    logic [PW-1:0]  fcw_q [NCH];
    logic [PW-1:0]  fcw_d [NCH];
    logic [PW-1:0]  off_q [NCH];
    logic [PW-1:0]  off_d [NCH];
    logic [PW-1:0]  acc_q [NCH];
    logic [PW-1:0]  acc_d [NCH];

    // Request bookkeeping and arbitration pointer
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [CW-1:0]  ptr_q, ptr_d;

    // Issue stage: the phase register plus its tag companion
    logic [PW-1:0]  phase_q, phase_d;
    logic           iss_vld_q, iss_vld_d;
    logic [CW-1:0]  iss_ch_q, iss_ch_d;

    // Tag line that tracks the core pipeline (the issue stage supplies the
    // extra register so the tail lines up with the core result)
    logic [LAT-1:0] tag_vld_q;
    logic [CW-1:0]  tag_ch_q [LAT];

    // Output stage
    logic           out_valid_q, out_valid_d;
    logic [CW-1:0]  out_ch_q, out_ch_d;
    logic [OW-1:0]  out_sin_q, out_sin_d;
    logic [OW-1:0]  out_cos_q, out_cos_d;

    // Arbiter results
    logic           gnt_vld_s;
    logic [CW-1:0]  gnt_ch_s;
    logic [CW-1:0]  cand_s;
    logic [NCH-1:0] grant_s;

    // Round-robin arbiter: first pending channel at or after ptr, wrapping
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_ch_s  = {CW{1'b0}};
        cand_s    = {CW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            cand_s = ptr_q + CW'(i);
            if (!gnt_vld_s && pending_q[cand_s]) begin
                gnt_vld_s = 1'b1;
                gnt_ch_s  = cand_s;
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
        if (gnt_vld_s) begin
            grant_s = {{(NCH-1){1'b0}}, 1'b1} << gnt_ch_s;
        end else begin
            grant_s = {NCH{1'b0}};
        end
    end

    // Next-state for requests, overruns, pointer and issue stage
    always_comb begin
        pending_d = (pending_q & ~grant_s & ch_en) | (req & ch_en);
        // a new request merging into an older, still-waiting one is an overrun;
        // set dominates a simultaneous clear
        ovf_d     = (ovf_clr ? {NCH{1'b0}} : ovf_q) | (req & ch_en & pending_q & ~grant_s);
        iss_vld_d = gnt_vld_s;
        iss_ch_d  = gnt_ch_s;
        if (gnt_vld_s) begin
            ptr_d   = gnt_ch_s + CW'(1);
            phase_d = acc_q[gnt_ch_s] + off_q[gnt_ch_s];
        end else begin
            ptr_d   = ptr_q;
            phase_d = phase_q;
        end
    end

    // Next-state for per-channel config and accumulators; a config write
    // overrides the accumulator advance of a same-cycle grant
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            fcw_d[c] = fcw_q[c];
            off_d[c] = off_q[c];
            acc_d[c] = acc_q[c];
            if (cfg_we && (cfg_ch == CW'(c))) begin
                fcw_d[c] = cfg_fcw;
                off_d[c] = cfg_off;
                acc_d[c] = {PW{1'b0}};
            end else if (grant_s[c]) begin
                acc_d[c] = acc_q[c] + fcw_q[c];
            end else begin
                acc_d[c] = acc_q[c];
            end
        end
    end

    // Next-state for output stage: data holds unless the tag tail is valid
    always_comb begin
        out_valid_d = tag_vld_q[LAT-1];
        out_ch_d    = tag_ch_q[LAT-1];
        if (tag_vld_q[LAT-1]) begin
            out_sin_d = cordic_sin;
            out_cos_d = cordic_cos;
        end else begin
            out_sin_d = out_sin_q;
            out_cos_d = out_cos_q;
        end
    end

    // State registers; reset also flushes the tag line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                fcw_q[c] <= {PW{1'b0}};
                off_q[c] <= {PW{1'b0}};
                acc_q[c] <= {PW{1'b0}};
            end
            pending_q   <= {NCH{1'b0}};
            ovf_q       <= {NCH{1'b0}};
            ptr_q       <= {CW{1'b0}};
            phase_q     <= {PW{1'b0}};
            iss_vld_q   <= 1'b0;
            iss_ch_q    <= {CW{1'b0}};
            tag_vld_q   <= {LAT{1'b0}};
            for (int k = 0; k < LAT; k++) begin
                tag_ch_q[k] <= {CW{1'b0}};
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= {CW{1'b0}};
            out_sin_q   <= {OW{1'b0}};
            out_cos_q   <= {OW{1'b0}};
        end else begin
            for (int c = 0; c < NCH; c++) begin
                fcw_q[c] <= fcw_d[c];
                off_q[c] <= off_d[c];
                acc_q[c] <= acc_d[c];
            end
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            phase_q     <= phase_d;
            iss_vld_q   <= iss_vld_d;
            iss_ch_q    <= iss_ch_d;
            tag_vld_q   <= {tag_vld_q[LAT-2:0], iss_vld_q};
            tag_ch_q[0] <= iss_ch_q;
            for (int k = 1; k < LAT; k++) begin
                tag_ch_q[k] <= tag_ch_q[k-1];
            end
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_sin_q   <= out_sin_d;
            out_cos_q   <= out_cos_d;
        end
    end

    assign pending      = pending_q;
    assign ovf          = ovf_q;
    assign cordic_phase = phase_q;
    assign out_valid    = out_valid_q;
    assign out_ch       = out_ch_q;
    assign out_sin      = out_sin_q;
    assign out_cos      = out_cos_q;

endmodule

// File: tb/tb_cordic_nco_sched.sv
// -----------------------------------------------------------------------------
// tb_cordic_nco_sched
//
// Directed scenarios followed by randomized traffic. A stand-in core delays
// cordic_phase by LAT cycles and returns slices of it as sin/cos, so every
// result can be traced back to the phase that produced it. A transaction-level
// reference model (per-channel arrays plus a queue of expected results with
// due cycles) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_cordic_nco_sched;

    localparam int NCH = 4;
    localparam int PW  = 32;
    localparam int LAT = 35;
    localparam int OW  = 18;

    logic            clk;
    logic            rst;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic [PW-1:0]   cfg_fcw;
    logic [PW-1:0]   cfg_off;
    logic [NCH-1:0]  ch_en;
    logic [NCH-1:0]  req;
    logic            ovf_clr;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  ovf;
    logic [PW-1:0]   cordic_phase;
    logic [OW-1:0]   cordic_sin;
    logic [OW-1:0]   cordic_cos;
    logic            out_valid;
    logic [1:0]      out_ch;
    logic [OW-1:0]   out_sin;
    logic [OW-1:0]   out_cos;

    cordic_nco_sched #(.NCH(NCH), .PW(PW), .LAT(LAT), .OW(OW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_fcw(cfg_fcw), .cfg_off(cfg_off), .ch_en(ch_en), .req(req),
        .ovf_clr(ovf_clr), .pending(pending), .ovf(ovf),
        .cordic_phase(cordic_phase), .cordic_sin(cordic_sin),
        .cordic_cos(cordic_cos), .out_valid(out_valid), .out_ch(out_ch),
        .out_sin(out_sin), .out_cos(out_cos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in core: samples the phase every edge, result LAT edges later.
    // It is deliberately not reset so stale data is present after a reset.
    logic [PW-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= cordic_phase;
        for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign cordic_sin = core_pipe[LAT-1][PW-1 -: OW];
    assign cordic_cos = core_pipe[LAT-1][OW-1:0];

    // Reference model
    typedef struct { int due; int ch; logic [PW-1:0] ph; } exp_t;
    exp_t            exp_q [$];
    logic [PW-1:0]   m_fcw [NCH];
    logic [PW-1:0]   m_off [NCH];
    logic [PW-1:0]   m_acc [NCH];
    logic [NCH-1:0]  m_pend;
    logic [NCH-1:0]  m_ovf;
    int              m_ptr;
    logic [PW-1:0]   m_phase;
    logic [OW-1:0]   m_sin;
    logic [OW-1:0]   m_cos;
    int              cyc;

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_fcw[c] = '0; m_off[c] = '0; m_acc[c] = '0;
        end
        m_pend = '0; m_ovf = '0; m_ptr = 0; m_phase = '0;
        m_sin = '0; m_cos = '0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (ev) begin
            chk("out_ch", 64'(out_ch), 64'(exp_q[0].ch));
            m_sin = exp_q[0].ph[PW-1 -: OW];
            m_cos = exp_q[0].ph[OW-1:0];
            void'(exp_q.pop_front());
        end
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_sin", 64'(out_sin), 64'(m_sin));
        chk("out_cos", 64'(out_cos), 64'(m_cos));
        chk("pending", 64'(pending), 64'(m_pend));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("cordic_phase", 64'(cordic_phase), 64'(m_phase));
    endtask

    // One clock: edge, advance the model with the inputs seen at the edge,
    // compare after the edge, then drop the one-shot inputs.
    task automatic tick();
        int g;
        logic [NCH-1:0] gv;
        @(posedge clk);
        cyc++;
        if (rst === 1'b0) begin
            model_reset();
        end else begin
            g = -1;
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_ptr + i) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
            gv = '0;
            if (g >= 0) begin
                gv[g]    = 1'b1;
                m_phase  = m_acc[g] + m_off[g];
                m_acc[g] = m_acc[g] + m_fcw[g];
                exp_q.push_back('{due: cyc + LAT + 1, ch: g, ph: m_phase});
                m_ptr    = (g + 1) % NCH;
            end
            m_ovf  = (ovf_clr ? '0 : m_ovf) | (req & ch_en & m_pend & ~gv);
            m_pend = (m_pend & ~gv & ch_en) | (req & ch_en);
            if (cfg_we) begin
                m_fcw[cfg_ch] = cfg_fcw;
                m_off[cfg_ch] = cfg_off;
                m_acc[cfg_ch] = '0;
            end
        end
        #1;
        check_outputs();
        req     = '0;
        cfg_we  = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic cfg(input int c, input logic [PW-1:0] f, input logic [PW-1:0] o);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(c);
        cfg_fcw = f;
        cfg_off = o;
    endtask

    logic [PW-1:0] t1_ph [4];
    int n0, lat, cnt;
    bit seen;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        t1_ph[0] = 32'h0000_0000; t1_ph[1] = 32'h4000_0000;
        t1_ph[2] = 32'h8000_0000; t1_ph[3] = 32'hC000_0000;
        rst = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_fcw = '0; cfg_off = '0;
        ch_en = '0; req = '0; ovf_clr = 1'b0;
        model_reset();

        // Reset state
        #2;
        check_outputs();
        tick();
        #2 rst = 1'b1;
        tick();

        // ch0 alone: quarter-turn steps, 37-cycle request-to-result latency
        ch_en = 4'b0001;
        cfg(0, 32'h4000_0000, 32'h0);
        tick();
        for (int r = 0; r < 4; r++) begin
            req = 4'b0001;
            tick();
            n0 = cyc;
            tick();
            chk("t1_phase", 64'(cordic_phase), 64'(t1_ph[r]));
            seen = 1'b0;
            lat  = 9999;
            for (int k = 0; k < 60 && !seen; k++) begin
                tick();
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    lat  = cyc - n0;
                end
            end
            chk("t1_latency", 64'(lat), 64'd37);
            while (cyc - n0 < 50) tick();
        end

        // All channels at once from ptr=0
        cfg(1, 32'h0100_0000, 32'h1000_0000); tick();
        cfg(2, 32'h0200_0000, 32'h2000_0000); tick();
        cfg(3, 32'h0300_0000, 32'h3000_0000); tick();
        ch_en = 4'b1111;
        req = 4'b1000; tick();
        tick();
        for (int k = 0; k < 45; k++) tick();
        req = 4'b1111; tick();
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_ch", 64'(out_ch), 64'(j));
            tick();
        end
        for (int k = 0; k < 5; k++) tick();

        // Overrun on ch1 while ch0 keeps requesting
        req = 4'b0101; tick();
        req = 4'b0001; tick();
        req = 4'b0011; tick();
        req = 4'b0011; tick();
        chk("t3_ovf1", 64'(ovf[1]), 64'd1);
        req = 4'b0001; tick();
        tick();
        ovf_clr = 1'b1; tick();
        chk("t3_ovf_clr", 64'(ovf), 64'd0);
        cnt = 0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (out_valid === 1'b1 && out_ch === 2'd1) cnt++;
        end
        chk("t3_ch1_issues", 64'(cnt), 64'd1);

        // Config write colliding with a ch2 grant
        cfg(2, 32'h1000_0000, 32'h2000_0000); tick();
        req = 4'b0100; tick();
        tick();
        chk("t4_first", 64'(cordic_phase), 64'h2000_0000);
        req = 4'b0100; tick();
        cfg(2, 32'h0100_0000, 32'h0);
        tick();
        chk("t4_old_vals", 64'(cordic_phase), 64'h3000_0000);
        req = 4'b0100; tick();
        tick();
        chk("t4_acc_cleared", 64'(cordic_phase), 64'h0);

        // Disabled channel ignores requests; disabling drops pending
        ch_en = 4'b0111;
        req = 4'b1000; tick();
        chk("t5_no_pend", 64'(pending), 64'd0);
        chk("t5_no_ovf", 64'(ovf), 64'd0);
        tick();
        ch_en = 4'b1111;
        req = 4'b0111; tick();
        req = 4'b1000; tick();
        chk("t5_pend3_set", 64'(pending[3]), 64'd1);
        ch_en = 4'b0111; tick();
        chk("t5_pend3_clr", 64'(pending[3]), 64'd0);
        ch_en = 4'b1111;
        for (int k = 0; k < 45; k++) tick();

        // Reset with issues in flight
        for (int k = 0; k < 12; k++) begin
            req = 4'b1111;
            tick();
        end
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        tick();
        #2 rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0) cnt++;
        end
        chk("t6_no_valid_after_rst", 64'(cnt), 64'd0);

        // Randomized traffic
        ch_en = 4'b1111;
        for (int c = 0; c < NCH; c++) begin
            cfg(c, $urandom, $urandom);
            tick();
        end
        for (int k = 0; k < 1500; k++) begin
            ch_en   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b1111;
            req     = 4'($urandom) & 4'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) cfg($urandom_range(0, NCH - 1), $urandom, $urandom);
            tick();
        end
        for (int k = 0; k < 45; k++) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
